rename_commit_sequencer: RTL and testbench
==========================================

Name: rename_commit_sequencer

Overview:
- Sits between the reorder buffer retire port and the register rename unit.
- Accepts up to 4 retiring instructions per cycle, buffers them in a small in-order FIFO, and presents them to the rename unit's single Commit port at one per cycle.
- Sequences branch-mispredict recovery. The rename unit restores its speculative map from the committed map, so all older commits must be applied before Branch_flush is asserted; this block drains its FIFO first, then raises the flush.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 4.
- CW, 4, occupancy counter width; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rob_valid  in  4  per-lane retire valid; lane 0 is oldest.
- rob_rdst0..rob_rdst3  in  5 each  architectural destination register per lane.
- rob_phy0..rob_phy3  in  6 each  physical destination register per lane.
- rob_ready  out  1  all 4 lanes may be accepted this cycle.
- flush_req  in  1  one-cycle mispredict pulse; lanes presented in the same cycle are older than the branch.
- Commit  out  1  to rename unit.
- Commit_Phy  out  6  to rename unit.
- Commit_Rdst  out  5  to rename unit.
- Branch_flush  out  1  to rename unit.
- rename_stall  out  1  ORed into the rename unit's Stall input.
- flush_done  out  1  one-cycle pulse; the rename map is restored from the next cycle on.
- occupancy  out  CW  current FIFO entry count.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, occupancy=0, state=RUN.
  - Commit=0, Branch_flush=0, flush_done=0, rename_stall=0, rob_ready=1.
  - Reset mid-drain abandons the flush; no Branch_flush is issued.
- Enqueue:
  - Accepted when rob_ready=1. rob_ready = (state==RUN) && (DEPTH-occupancy >= 4), evaluated on the current occupancy, before any same-cycle dequeue.
  - Lanes with rob_valid=1 and rob_rdst!=0 are written in lane order, packed contiguously (gaps skipped) at the tail.
  - Lanes with rob_rdst==0 are dropped.
  - Lane data presented while rob_ready=0 is ignored; the ROB holds it.
- Dequeue:
  - Commit = (occupancy!=0).
  - Commit_Phy and Commit_Rdst come from the head entry combinationally; both are 0 when empty.
  - The head pops every cycle Commit=1; the rename unit never back-pressures.
  - An entry enqueued at edge N is visible on Commit in cycle N+1.
- Occupancy update: occupancy_next = occupancy + enq_count - Commit. Pointers wrap modulo DEPTH. Simultaneous enqueue and dequeue are legal.
- FSM, three states: RUN, DRAIN, POST.
  - RUN, flush_req=1: same-cycle lanes are enqueued if rob_ready; next state DRAIN. flush_req in any other state is ignored.
  - DRAIN:
    - rob_ready=0 and rename_stall=1; one commit per cycle continues.
    - Branch_flush=1 in the cycle occupancy<=1, together with the last Commit if occupancy==1, or alone if occupancy==0.
    - flush_done=1 in that same cycle; next state POST.
  - POST (one cycle): rename_stall=1, rob_ready=0, Commit=0; next state RUN.
- Branch_flush is asserted for exactly one cycle per accepted flush_req.
- rename_stall=0 in RUN.

Test Plan:
- Reset then idle: rst_n low for 2 cycles -> rob_ready=1, Commit=0, occupancy=0.
- Four valid lanes, rdst={1,2,3,4}, phy={10,11,12,13}, one cycle -> Commit high for cycles N+1..N+4 with (Rdst,Phy) = (1,10),(2,11),(3,12),(4,13) in order; occupancy goes 4,3,2,1,0.
- rob_valid=4'b1010 with lane1 rdst=0 -> only lane3 is enqueued; occupancy=1.
- DEPTH=8: present 4 lanes on 3 consecutive cycles -> first two bursts accepted; rob_ready drops when occupancy reaches 7 (not ≥4 free); ROB holds the third burst.
- FIFO holds 3 entries, flush_req pulsed with 2 new lanes -> occupancy becomes 4, then 5 commits issue. Branch_flush and flush_done coincide with the 5th Commit, then one POST cycle, then RUN with rob_ready=1. A second flush_req during DRAIN is ignored.
- Flush with empty FIFO -> Branch_flush in the first DRAIN cycle with Commit=0. rst_n asserted during DRAIN with 3 entries pending -> immediate return to RUN, empty FIFO, no Branch_flush.

Source files
------------

// File: rtl/rename_commit_sequencer.sv
// Buffers up to four retiring ROB lanes per cycle and feeds them one per cycle to the
// rename unit's commit port; drains all older commits before issuing a branch flush.
module rename_commit_sequencer #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    rob_valid,
    input  logic [4:0]    rob_rdst0,
    input  logic [4:0]    rob_rdst1,
    input  logic [4:0]    rob_rdst2,
    input  logic [4:0]    rob_rdst3,
    input  logic [5:0]    rob_phy0,
    input  logic [5:0]    rob_phy1,
    input  logic [5:0]    rob_phy2,
    input  logic [5:0]    rob_phy3,
    output logic          rob_ready,
    input  logic          flush_req,
    output logic          Commit,
    output logic [5:0]    Commit_Phy,
    output logic [4:0]    Commit_Rdst,
    output logic          Branch_flush,
    output logic          rename_stall,
    output logic          flush_done,
    output logic [CW-1:0] occupancy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, POST} state_t;

    state_t        state, state_nxt;
    logic [4:0]    mem_rdst [DEPTH];
    logic [5:0]    mem_phy  [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] occ;

    logic [4:0]    lane_rdst [4];
    logic [5:0]    lane_phy  [4];
    logic [3:0]    lane_en;
    logic [2:0]    lane_off  [4];
    logic [2:0]    enq_cnt;
    logic          drain_last;

    assign lane_rdst[0] = rob_rdst0;
    assign lane_rdst[1] = rob_rdst1;
    assign lane_rdst[2] = rob_rdst2;
    assign lane_rdst[3] = rob_rdst3;
    assign lane_phy[0]  = rob_phy0;
    assign lane_phy[1]  = rob_phy1;
    assign lane_phy[2]  = rob_phy2;
    assign lane_phy[3]  = rob_phy3;

    // Ready needs room for a full 4-lane burst, judged before any same-cycle pop.
    assign rob_ready    = (state == RUN) && (occ <= CW'(DEPTH - 4));
    assign Commit       = (occ != '0);
    assign Commit_Rdst  = Commit ? mem_rdst[rd_ptr] : '0;
    assign Commit_Phy   = Commit ? mem_phy[rd_ptr]  : '0;
    assign drain_last   = (state == DRAIN) && (occ <= CW'(1));
    assign Branch_flush = drain_last;
    assign flush_done   = drain_last;
    assign rename_stall = (state != RUN);
    assign occupancy    = occ;

    // Surviving lanes are packed contiguously at the tail; offset = count of older survivors.
    always_comb begin
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < 4; i++) begin
            lane_off[i] = cnt;
            lane_en[i]  = rob_ready && rob_valid[i] && (lane_rdst[i] != 5'd0);
            if (lane_en[i]) cnt = cnt + 3'd1;
        end
        enq_cnt = cnt;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                mem_rdst[wr_ptr + AW'(lane_off[i])] <= lane_rdst[i];
                mem_phy[wr_ptr + AW'(lane_off[i])]  <= lane_phy[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr + AW'(enq_cnt);
            rd_ptr <= rd_ptr + AW'(Commit);
            occ    <= occ + CW'(enq_cnt) - CW'(Commit);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush_req) state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = POST;
            POST:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end
endmodule

// File: tb/tb_rename_commit_sequencer.sv
// Randomized and directed bench for rename_commit_sequencer against a queue-based model.
module tb_rename_commit_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rob_valid;
    logic [4:0] in_rdst [4];
    logic [5:0] in_phy  [4];
    logic       flush_req;
    logic       rob_ready, Commit, Branch_flush, rename_stall, flush_done;
    logic [5:0] Commit_Phy;
    logic [4:0] Commit_Rdst;
    logic [3:0] occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [4:0] rdst;
        logic [5:0] phy;
    } ent_t;

    ent_t q[$];
    int   mode;  // 0 = accepting, 1 = draining for a flush, 2 = one-cycle recovery

    always #5 clk = ~clk;

    rename_commit_sequencer #(.DEPTH(8), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .rob_valid(rob_valid),
        .rob_rdst0(in_rdst[0]), .rob_rdst1(in_rdst[1]),
        .rob_rdst2(in_rdst[2]), .rob_rdst3(in_rdst[3]),
        .rob_phy0(in_phy[0]), .rob_phy1(in_phy[1]),
        .rob_phy2(in_phy[2]), .rob_phy3(in_phy[3]),
        .rob_ready(rob_ready), .flush_req(flush_req),
        .Commit(Commit), .Commit_Phy(Commit_Phy), .Commit_Rdst(Commit_Rdst),
        .Branch_flush(Branch_flush), .rename_stall(rename_stall),
        .flush_done(flush_done), .occupancy(occupancy)
    );

    function automatic logic [19:0] exp_vec();
        logic       rdy, cm, bf;
        logic [4:0] rd;
        logic [5:0] ph;
        rdy = (mode == 0) && ((8 - q.size()) >= 4);
        cm  = (q.size() != 0);
        bf  = (mode == 1) && (q.size() <= 1);
        rd  = '0;
        ph  = '0;
        if (q.size() != 0) begin
            rd = q[0].rdst;
            ph = q[0].phy;
        end
        return {rdy, cm, rd, ph, bf, (mode != 0), bf, 4'(q.size())};
    endfunction

    task automatic set_in(input logic [3:0] v, input logic [19:0] rd, input logic [23:0] ph,
                          input logic fr);
        rob_valid = v;
        for (int i = 0; i < 4; i++) begin
            in_rdst[i] = rd[i*5 +: 5];
            in_phy[i]  = ph[i*6 +: 6];
        end
        flush_req = fr;
    endtask

    // Model advances on the edge using the rules, then returns at the next falling edge.
    task automatic advance();
        bit   rdy, bf;
        int   nm;
        ent_t e;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            mode = 0;
        end else begin
            rdy = (mode == 0) && ((8 - q.size()) >= 4);
            bf  = (mode == 1) && (q.size() <= 1);
            nm  = mode;
            if (q.size() != 0) void'(q.pop_front());
            if (rdy) begin
                for (int i = 0; i < 4; i++) begin
                    if (rob_valid[i] && in_rdst[i] != 5'd0) begin
                        e.rdst = in_rdst[i];
                        e.phy  = in_phy[i];
                        q.push_back(e);
                    end
                end
            end
            case (mode)
                0: if (flush_req) nm = 1;
                1: if (bf) nm = 2;
                default: nm = 0;
            endcase
            mode = nm;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(4'h0, '0, '0, 1'b0);
        advance();
        advance();
        n_checks++;
        if ({rob_ready, Commit, occupancy, Branch_flush, rename_stall, flush_done} !== {1'b1, 1'b0, 4'd0, 3'b000})
            $display("FAIL reset_state: got rdy=%b cm=%b occ=%0d bf=%b st=%b fd=%b, want 1 0 0 0 0 0",
                     rob_ready, Commit, occupancy, Branch_flush, rename_stall, flush_done);
        else n_pass++;
        rst_n = 1'b1;
        advance();
    endtask

    task automatic test_four_lanes();
        set_in(4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {6'd13, 6'd12, 6'd11, 6'd10}, 1'b0);
        advance();
        set_in(4'h0, '0, '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({Commit, Commit_Rdst, Commit_Phy, occupancy} !== {1'b1, 5'(k + 1), 6'(k + 10), 4'(4 - k)})
                $display("FAIL four_lanes[%0d]: got cm=%b rd=%0d ph=%0d occ=%0d, want 1 %0d %0d %0d",
                         k, Commit, Commit_Rdst, Commit_Phy, occupancy, k + 1, k + 10, 4 - k);
            else n_pass++;
            advance();
        end
        n_checks++;
        if ({Commit, occupancy, Commit_Rdst, Commit_Phy} !== 16'd0)
            $display("FAIL four_lanes_empty: got cm=%b occ=%0d rd=%0d ph=%0d, want all 0",
                     Commit, occupancy, Commit_Rdst, Commit_Phy);
        else n_pass++;
    endtask

    task automatic test_sparse();
        set_in(4'b1010, {5'd7, 5'd6, 5'd0, 5'd5}, {6'd33, 6'd32, 6'd31, 6'd30}, 1'b0);
        advance();
        set_in(4'h0, '0, '0, 1'b0);
        n_checks++;
        if ({occupancy, Commit_Rdst, Commit_Phy} !== {4'd1, 5'd7, 6'd33})
            $display("FAIL sparse: got occ=%0d rd=%0d ph=%0d, want 1 7 33", occupancy, Commit_Rdst, Commit_Phy);
        else n_pass++;
        advance();
    endtask

    task automatic test_back_to_back();
        logic [2:0] rdy_seen;
        int         next_rd, commits;
        for (int b = 0; b < 3; b++) begin
            set_in(4'hF, {5'(b*4+4), 5'(b*4+3), 5'(b*4+2), 5'(b*4+1)},
                   {6'(20+b*4+3), 6'(20+b*4+2), 6'(20+b*4+1), 6'(20+b*4)}, 1'b0);
            rdy_seen[b] = rob_ready;
            advance();
        end
        n_checks++;
        if (rdy_seen !== 3'b011)
            $display("FAIL backpressure_ready: got %b (burst2..0), want 011", rdy_seen);
        else n_pass++;
        set_in(4'h0, '0, '0, 1'b0);
        n_checks++;
        if (occupancy !== 4'd6)
            $display("FAIL backpressure_occ: got %0d, want 6", occupancy);
        else n_pass++;
        next_rd = 3;
        commits = 2;
        for (int c = 0; c < 9; c++) begin
            if (Commit) begin
                n_checks++;
                if (Commit_Rdst !== 5'(next_rd))
                    $display("FAIL backpressure_order: got rd=%0d, want %0d", Commit_Rdst, next_rd);
                else n_pass++;
                next_rd++;
                commits++;
            end
            advance();
        end
        n_checks++;
        if (commits !== 8)
            $display("FAIL backpressure_total: got %0d commits, want 8", commits);
        else n_pass++;
    endtask

    task automatic test_flush();
        int commits, k, bf_after;
        set_in(4'b0111, {5'd0, 5'd3, 5'd2, 5'd1}, {6'd0, 6'd42, 6'd41, 6'd40}, 1'b0);
        advance();
        set_in(4'b0011, {5'd0, 5'd0, 5'd5, 5'd4}, {6'd0, 6'd0, 6'd44, 6'd43}, 1'b1);
        n_checks++;
        if ({occupancy, rob_ready} !== {4'd3, 1'b1})
            $display("FAIL flush_pre: got occ=%0d rdy=%b, want 3 1", occupancy, rob_ready);
        else n_pass++;
        commits = Commit ? 1 : 0;
        advance();
        n_checks++;
        if ({occupancy, rename_stall, rob_ready} !== {4'd4, 1'b1, 1'b0})
            $display("FAIL flush_drain: got occ=%0d st=%b rdy=%b, want 4 1 0", occupancy, rename_stall, rob_ready);
        else n_pass++;
        k = 0;
        while (!Branch_flush && k < 8) begin
            if (Commit) commits++;
            set_in(4'h0, '0, '0, k == 0);
            advance();
            k++;
        end
        if (Commit) commits++;
        n_checks++;
        if ({Branch_flush, flush_done, Commit, 4'(commits)} !== {3'b111, 4'd5})
            $display("FAIL flush_coincide: got bf=%b fd=%b cm=%b commits=%0d, want 1 1 1 5",
                     Branch_flush, flush_done, Commit, commits);
        else n_pass++;
        set_in(4'h0, '0, '0, 1'b0);
        advance();
        n_checks++;
        if ({rename_stall, rob_ready, Commit, Branch_flush} !== 4'b1000)
            $display("FAIL flush_post: got st=%b rdy=%b cm=%b bf=%b, want 1 0 0 0",
                     rename_stall, rob_ready, Commit, Branch_flush);
        else n_pass++;
        advance();
        bf_after = 0;
        n_checks++;
        if ({rename_stall, rob_ready} !== 2'b01)
            $display("FAIL flush_run: got st=%b rdy=%b, want 0 1", rename_stall, rob_ready);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            if (Branch_flush) bf_after++;
            advance();
        end
        n_checks++;
        if (bf_after !== 0)
            $display("FAIL flush_second_ignored: got %0d extra flushes, want 0", bf_after);
        else n_pass++;
    endtask

    task automatic test_flush_empty();
        set_in(4'h0, '0, '0, 1'b1);
        advance();
        set_in(4'h0, '0, '0, 1'b0);
        n_checks++;
        if ({Branch_flush, flush_done, Commit, rename_stall} !== 4'b1101)
            $display("FAIL flush_empty: got bf=%b fd=%b cm=%b st=%b, want 1 1 0 1",
                     Branch_flush, flush_done, Commit, rename_stall);
        else n_pass++;
        advance();
        advance();
    endtask

    task automatic test_reset_mid_drain();
        int bf_cnt;
        set_in(4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {6'd53, 6'd52, 6'd51, 6'd50}, 1'b0);
        advance();
        set_in(4'h0, '0, '0, 1'b1);
        advance();
        set_in(4'h0, '0, '0, 1'b0);
        n_checks++;
        if ({occupancy, rename_stall} !== {4'd3, 1'b1})
            $display("FAIL mid_drain_pre: got occ=%0d st=%b, want 3 1", occupancy, rename_stall);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({occupancy, rob_ready, Commit, Branch_flush, rename_stall} !== {4'd0, 4'b1000})
            $display("FAIL mid_drain_reset: got occ=%0d rdy=%b cm=%b bf=%b st=%b, want 0 1 0 0 0",
                     occupancy, rob_ready, Commit, Branch_flush, rename_stall);
        else n_pass++;
        advance();
        rst_n = 1'b1;
        bf_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (Branch_flush) bf_cnt++;
            advance();
        end
        n_checks++;
        if (bf_cnt !== 0)
            $display("FAIL mid_drain_noflush: got %0d flushes, want 0", bf_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [19:0] rd, ev;
        logic [23:0] ph;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                rd[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                ph[i*6 +: 6] = 6'($urandom_range(0, 63));
            end
            set_in(4'($urandom_range(0, 15)), rd, ph, $urandom_range(0, 15) == 0);
            #1;
            ev = exp_vec();
            n_checks++;
            if ({rob_ready, Commit, Commit_Rdst, Commit_Phy, Branch_flush, rename_stall, flush_done, occupancy} !== ev)
                $display("FAIL random[%0d]: got %h, want %h (rdy,cm,rd,ph,bf,st,fd,occ)", c,
                         {rob_ready, Commit, Commit_Rdst, Commit_Phy, Branch_flush, rename_stall, flush_done, occupancy}, ev);
            else n_pass++;
            advance();
        end
    endtask

    initial begin
        q.delete();
        mode = 0;
        test_reset();
        test_four_lanes();
        test_sparse();
        test_back_to_back();
        test_flush();
        test_flush_empty();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
